train_countdown_ctrl: RTL
=========================

# train_countdown_ctrl

Upstream digit source for the metro station platform display. It counts down to the next train's arrival and holds the doors open for a dwell period, then shows a departure pattern. It drives the four 5-bit digit codes (`ones`, `tens`, `hundreds`, `thousands`) consumed by `SegmentDisplay`, replacing the free-running `Display` counter. Timing comes from a single-cycle 10 Hz enable pulse, so everything runs on the one system clock.

## Interface
Parameters:
- `TICKS_PER_S`, default 10: tick pulses per displayed second; range 1..15.
- `HEADWAY_S`, default 120: seconds of arrival countdown; range 1..5999 (at most 99:59).
- `DWELL_S`, default 20: door-open seconds; range 1..99.
- `DEPART_S`, default 3: departure-pattern seconds; range 1..15.

Ports:
- `clk`, input, 1: system clock (Basys 3 100 MHz); all logic runs on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `tick_10hz`, input, 1: one-`clk`-wide enable pulse at 10 Hz.
- `hold`, input, 1: operator hold; freezes all timing while high.
- `thousands`, output, 5: leftmost digit code.
- `hundreds`, output, 5: digit code.
- `tens`, output, 5: digit code.
- `ones`, output, 5: rightmost digit code.
- `door_open`, output, 1: high throughout DWELL.
- `train_arrive`, output, 1: one-`clk` pulse on the COUNTDOWN→DWELL transition.

## Operation
- Digit codes: 0..9 are numerals. Glyph codes are 16 = blank, 17 = 'd', 20 = '-'. All other codes are unused and must never be driven.
- Prescaler: counts accepted ticks from 0 to TICKS_PER_S-1.
  - A second strobe occurs on an accepted tick while the count equals TICKS_PER_S-1. The count wraps to 0 on that tick.
  - The prescaler is not cleared on state transitions.
- A tick is accepted only when `tick_10hz`=1 and `hold`=0. If hold and tick are high in the same cycle, hold wins and the tick is lost.
- States (enum in the package):
  - COUNTDOWN
    - Display is mm:ss: thousands = minute tens, hundreds = minute ones, tens = second tens, ones = second ones.
    - Loaded with HEADWAY_S converted to mm:ss. It shows HEADWAY_S down to 1.
    - A strobe at 00:01 moves to DWELL, pulses `train_arrive`, and loads DWELL_S.
  - DWELL
    - Display is 'd', blank, then the two BCD digits of the remaining seconds.
    - Shows DWELL_S down to 1. A strobe at 1 moves to DEPART and loads DEPART_S.
    - `door_open`=1 in this state.
  - DEPART
    - Display is '-','-','-','-'.
    - A strobe with 1 second remaining moves to COUNTDOWN and reloads HEADWAY_S.
- Each state therefore lasts exactly its parameter in seconds while hold is low.
- Arithmetic: remaining time is held directly as a BCD mm:ss down-counter, with no binary-to-BCD division.
  - ss borrows 00→59 and decrements mm, so 01:00 is followed by 00:59.
  - The counter never goes below 00:01, because the transition fires first.
- `hold` high: state, counter and prescaler are frozen and the outputs are unchanged. On release, timing resumes from the frozen prescaler value.
- Reset (asserted at any time, including mid-DWELL):
  - Next edge gives state COUNTDOWN, counter = HEADWAY_S, prescaler 0.
  - `door_open`=0, `train_arrive`=0.
  - Digits show HEADWAY_S as mm:ss; for the default, thousands=0, hundreds=2, tens=0, ones=0.

## Timing
- All outputs are registered.
- A change caused by an accepted tick at edge N is visible after edge N+1 at the latest, i.e. one cycle of latency.
- Transition, counter reload, digit update and `train_arrive` all occur on the same edge. `train_arrive` is high for exactly one cycle.
- `door_open` rises with the first DWELL display and falls with the first DEPART display.
- Ticks arriving less than TICKS_PER_S apart have no special handling; every accepted tick counts.

## Structure
- Package `metro_pkg`:
  - Glyph constants `GLYPH_BLANK`=16, `GLYPH_D`=17, `GLYPH_DASH`=20.
  - State enum.
  - `SegmentDisplay` must import the same glyph codes so it decodes them.
- Sub-module `mmss_bcd_down`:
  - Loadable 4-digit BCD down-counter with decrement enable, ss borrow wrap at 59, and a `is_one` flag.
  - Reused for the dwell and depart counts with the mm digits held at 0.

## Test plan
All scenarios use TICKS_PER_S=2, HEADWAY_S=65, DWELL_S=3, DEPART_S=2.
1. Release reset → digits 0,1,0,5 (01:05); `door_open`=0; `train_arrive`=0.
2. 2 ticks → 01:04. 12 ticks in total → 00:59, checking the borrow from 01:00.
3. 130 ticks from reset → `train_arrive` is exactly one cycle wide; `door_open`=1; display is d, blank, 0, 3.
4. 6 further ticks → display '----' and `door_open`=0. 4 further ticks → 01:05 again.
5. `hold`=1 across 10 ticks at 00:40 → display, state and prescaler unchanged. Then `hold` and a tick in the same cycle → the tick is ignored. Release hold → the next 2 ticks give 00:39.
6. `rst_n`=0 for one cycle mid-DWELL → next cycle shows 01:05, `door_open`=0, and `train_arrive` does not pulse.

Source files
------------

// File: rtl/metro_pkg.sv
// Shared definitions for the metro platform display: glyph codes understood
// by SegmentDisplay and the platform controller state encoding.
package metro_pkg;

  localparam logic [4:0] GLYPH_BLANK = 5'd16;
  localparam logic [4:0] GLYPH_D     = 5'd17;
  localparam logic [4:0] GLYPH_DASH  = 5'd20;

  typedef enum logic [1:0] {
    ST_COUNTDOWN = 2'd0,
    ST_DWELL     = 2'd1,
    ST_DEPART    = 2'd2
  } state_e;

  // Numeral digit code: a BCD digit with the glyph bit clear.
  function automatic logic [4:0] num_code(input logic [3:0] bcd);
    return {1'b0, bcd};
  endfunction

endpackage

// File: rtl/mmss_bcd_down.sv
// Loadable BCD mm:ss down-counter. Seconds borrow 00 -> 59 and decrement the
// minutes. Load has priority over decrement. Exposes the next-cycle digits so
// the owner can register its outputs in step with the counter.
module mmss_bcd_down (
  input  logic       clk,
  input  logic       load,
  input  logic [3:0] ld_m10,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_s10,
  input  logic [3:0] ld_s1,
  input  logic       dec,
  output logic [3:0] m10_nxt,
  output logic [3:0] m1_nxt,
  output logic [3:0] s10_nxt,
  output logic [3:0] s1_nxt,
  output logic       is_one
);

  logic [3:0] m10_q, m1_q, s10_q, s1_q;
  logic [3:0] m10_d, m1_d, s10_d, s1_d;

  // Next count: load, or decrement with ripple borrow through the BCD digits.
  always_comb begin
    m10_d = m10_q;
    m1_d  = m1_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    if (load) begin
      m10_d = ld_m10;
      m1_d  = ld_m1;
      s10_d = ld_s10;
      s1_d  = ld_s1;
    end else if (dec) begin
      if (s1_q != 4'd0) begin
        s1_d = s1_q - 4'd1;
      end else begin
        s1_d = 4'd9;
        if (s10_q != 4'd0) begin
          s10_d = s10_q - 4'd1;
        end else begin
          s10_d = 4'd5;
          if (m1_q != 4'd0) begin
            m1_d = m1_q - 4'd1;
          end else begin
            m1_d  = 4'd9;
            m10_d = m10_q - 4'd1;
          end
        end
      end
    end
  end

  // Counter digit registers; the owner loads them during reset.
  always_ff @(posedge clk) begin
    m10_q <= m10_d;
    m1_q  <= m1_d;
    s10_q <= s10_d;
    s1_q  <= s1_d;
  end

  assign m10_nxt = m10_d;
  assign m1_nxt  = m1_d;
  assign s10_nxt = s10_d;
  assign s1_nxt  = s1_d;
  assign is_one  = (m10_q == 4'd0) && (m1_q == 4'd0) &&
                   (s10_q == 4'd0) && (s1_q == 4'd1);

endmodule

// File: rtl/train_countdown_ctrl.sv
// Platform display controller: arrival countdown (mm:ss), door dwell
// ('d', blank, ss) and departure pattern ('----'), paced by a 10 Hz tick.
module train_countdown_ctrl
  import metro_pkg::*;
#(
  parameter int TICKS_PER_S = 10,
  parameter int HEADWAY_S   = 120,
  parameter int DWELL_S     = 20,
  parameter int DEPART_S    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_10hz,
  input  logic       hold,
  output logic [4:0] thousands,
  output logic [4:0] hundreds,
  output logic [4:0] tens,
  output logic [4:0] ones,
  output logic       door_open,
  output logic       train_arrive
);

  localparam logic [3:0] PRESC_MAX = 4'(TICKS_PER_S - 1);
  localparam int         HW_MIN    = HEADWAY_S / 60;
  localparam int         HW_SEC    = HEADWAY_S % 60;
  localparam logic [3:0] HW_M10    = 4'(HW_MIN / 10);
  localparam logic [3:0] HW_M1     = 4'(HW_MIN % 10);
  localparam logic [3:0] HW_S10    = 4'(HW_SEC / 10);
  localparam logic [3:0] HW_S1     = 4'(HW_SEC % 10);
  localparam logic [3:0] DW_S10    = 4'(DWELL_S / 10);
  localparam logic [3:0] DW_S1     = 4'(DWELL_S % 10);
  localparam logic [3:0] DP_S10    = 4'(DEPART_S / 10);
  localparam logic [3:0] DP_S1     = 4'(DEPART_S % 10);

  state_e     state_q, state_d;
  logic [3:0] presc_q, presc_d;
  logic       tick_acc, sec_strobe;

  logic       cnt_load, cnt_dec, cnt_is_one;
  logic [3:0] ld_m10, ld_m1, ld_s10, ld_s1;
  logic [3:0] m10_nxt, m1_nxt, s10_nxt, s1_nxt;

  logic [4:0] thousands_q, thousands_d;
  logic [4:0] hundreds_q, hundreds_d;
  logic [4:0] tens_q, tens_d;
  logic [4:0] ones_q, ones_d;
  logic       door_open_q, door_open_d;
  logic       train_arrive_q, train_arrive_d;

  // Prescaler: hold masks the tick; the last tick of each second wraps to 0.
  always_comb begin
    tick_acc   = tick_10hz & ~hold;
    sec_strobe = tick_acc && (presc_q == PRESC_MAX);
    presc_d    = presc_q;
    if (tick_acc) begin
      presc_d = sec_strobe ? 4'd0 : presc_q + 4'd1;
    end
  end

  // Phase sequencing: each second either decrements the remaining time or,
  // at one second left, moves on and reloads the next phase's duration.
  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    ld_m10         = 4'd0;
    ld_m1          = 4'd0;
    ld_s10         = 4'd0;
    ld_s1          = 4'd0;
    train_arrive_d = 1'b0;
    if (!rst_n) begin
      state_d  = ST_COUNTDOWN;
      cnt_load = 1'b1;
      ld_m10   = HW_M10;
      ld_m1    = HW_M1;
      ld_s10   = HW_S10;
      ld_s1    = HW_S1;
    end else if (sec_strobe) begin
      if (cnt_is_one) begin
        cnt_load = 1'b1;
        case (state_q)
          ST_COUNTDOWN: begin
            state_d        = ST_DWELL;
            ld_s10         = DW_S10;
            ld_s1          = DW_S1;
            train_arrive_d = 1'b1;
          end
          ST_DWELL: begin
            state_d = ST_DEPART;
            ld_s10  = DP_S10;
            ld_s1   = DP_S1;
          end
          default: begin
            state_d = ST_COUNTDOWN;
            ld_m10  = HW_M10;
            ld_m1   = HW_M1;
            ld_s10  = HW_S10;
            ld_s1   = HW_S1;
          end
        endcase
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

  mmss_bcd_down u_cnt (
    .clk     (clk),
    .load    (cnt_load),
    .ld_m10  (ld_m10),
    .ld_m1   (ld_m1),
    .ld_s10  (ld_s10),
    .ld_s1   (ld_s1),
    .dec     (cnt_dec),
    .m10_nxt (m10_nxt),
    .m1_nxt  (m1_nxt),
    .s10_nxt (s10_nxt),
    .s1_nxt  (s1_nxt),
    .is_one  (cnt_is_one)
  );

  // Display decode from next state and next count so the registered digits
  // change on the same edge as the state and counter.
  always_comb begin
    door_open_d = (state_d == ST_DWELL);
    case (state_d)
      ST_COUNTDOWN: begin
        thousands_d = num_code(m10_nxt);
        hundreds_d  = num_code(m1_nxt);
        tens_d      = num_code(s10_nxt);
        ones_d      = num_code(s1_nxt);
      end
      ST_DWELL: begin
        thousands_d = GLYPH_D;
        hundreds_d  = GLYPH_BLANK;
        tens_d      = num_code(s10_nxt);
        ones_d      = num_code(s1_nxt);
      end
      default: begin
        thousands_d = GLYPH_DASH;
        hundreds_d  = GLYPH_DASH;
        tens_d      = GLYPH_DASH;
        ones_d      = GLYPH_DASH;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_COUNTDOWN;
      presc_q        <= 4'd0;
      thousands_q    <= num_code(HW_M10);
      hundreds_q     <= num_code(HW_M1);
      tens_q         <= num_code(HW_S10);
      ones_q         <= num_code(HW_S1);
      door_open_q    <= 1'b0;
      train_arrive_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      thousands_q    <= thousands_d;
      hundreds_q     <= hundreds_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
      door_open_q    <= door_open_d;
      train_arrive_q <= train_arrive_d;
    end
  end

  assign thousands    = thousands_q;
  assign hundreds     = hundreds_q;
  assign tens         = tens_q;
  assign ones         = ones_q;
  assign door_open    = door_open_q;
  assign train_arrive = train_arrive_q;

endmodule
